// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: drives the data-memory req/ack access, stalls upstream while it is pending, registers MEM/WB.
// Optional access timeout with a sticky error flag is enabled by defining MEM_TIMEOUT_EN.
module mem_stage_ctrl #(
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] PC_plus1_in,
    input  logic [2:0]        WB_in,
    input  logic [1:0]        Memory_in,
    input  logic [DATA_W-1:0] ALU_in,
    input  logic [DATA_W-1:0] Memory_data_write_in,
    input  logic [DATA_W-1:0] Zero_pad_in,
    input  logic [2:0]        Dest_in,
    output logic              stall_out,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              valid_out,
    output logic [2:0]        WB_out,
    output logic [2:0]        Dest_out,
    output logic [DATA_W-1:0] WB_data_out,
    output logic              reg_write_out,
    output logic              mem_err
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t            state_q, state_d;
    logic              memWe_q, memWe_d;
    logic [DATA_W-1:0] memAddr_q, memAddr_d;
    logic [DATA_W-1:0] memWdata_q, memWdata_d;
    logic [2:0]        capWb_q, capWb_d;
    logic [2:0]        capDest_q, capDest_d;
    logic [DATA_W-1:0] capPc_q, capPc_d;
    logic [DATA_W-1:0] capAlu_q, capAlu_d;
    logic [DATA_W-1:0] capZp_q, capZp_d;
    logic              capLoad_q, capLoad_d;
    logic              valid_q, valid_d;
    logic [2:0]        wb_q, wb_d;
    logic [2:0]        dest_q, dest_d;
    logic [DATA_W-1:0] wbData_q, wbData_d;
`ifdef MEM_TIMEOUT_EN
    logic [4:0]        cnt_q, cnt_d;
    logic              err_q, err_d;
`endif

    function automatic logic [DATA_W-1:0] selectWb(
        input logic [1:0]        sel,
        input logic [DATA_W-1:0] alu,
        input logic [DATA_W-1:0] memData,
        input logic [DATA_W-1:0] zeroPad,
        input logic [DATA_W-1:0] pcPlus1
    );
        case (sel)
            2'b00:   return alu;
            2'b01:   return memData;
            2'b10:   return zeroPad;
            default: return pcPlus1;
        endcase
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            capWb_q    <= '0;
            capDest_q  <= '0;
            capPc_q    <= '0;
            capAlu_q   <= '0;
            capZp_q    <= '0;
            capLoad_q  <= 1'b0;
            valid_q    <= 1'b0;
            wb_q       <= '0;
            dest_q     <= '0;
            wbData_q   <= '0;
`ifdef MEM_TIMEOUT_EN
            cnt_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            memWe_q    <= memWe_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
            capWb_q    <= capWb_d;
            capDest_q  <= capDest_d;
            capPc_q    <= capPc_d;
            capAlu_q   <= capAlu_d;
            capZp_q    <= capZp_d;
            capLoad_q  <= capLoad_d;
            valid_q    <= valid_d;
            wb_q       <= wb_d;
            dest_q     <= dest_d;
            wbData_q   <= wbData_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q      <= cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    // MEM/WB defaults to a bubble every edge; only a retiring instruction overrides it.
    always_comb begin
        state_d    = state_q;
        memWe_d    = memWe_q;
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;
        capWb_d    = capWb_q;
        capDest_d  = capDest_q;
        capPc_d    = capPc_q;
        capAlu_d   = capAlu_q;
        capZp_d    = capZp_q;
        capLoad_d  = capLoad_q;
        valid_d    = 1'b0;
        wb_d       = '0;
        dest_d     = '0;
        wbData_d   = '0;
`ifdef MEM_TIMEOUT_EN
        cnt_d      = cnt_q;
        err_d      = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    if (Memory_in == 2'b00) begin
                        valid_d  = 1'b1;
                        wb_d     = WB_in;
                        dest_d   = Dest_in;
                        wbData_d = selectWb(WB_in[1:0], ALU_in, '0, Zero_pad_in, PC_plus1_in);
                    end else begin
                        state_d    = ACCESS;
                        memWe_d    = (Memory_in == 2'b01);
                        memAddr_d  = ALU_in;
                        memWdata_d = Memory_data_write_in;
                        capWb_d    = WB_in;
                        capDest_d  = Dest_in;
                        capPc_d    = PC_plus1_in;
                        capAlu_d   = ALU_in;
                        capZp_d    = Zero_pad_in;
                        capLoad_d  = Memory_in[1];
`ifdef MEM_TIMEOUT_EN
                        cnt_d      = '0;
`endif
                    end
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    state_d  = IDLE;
                    valid_d  = 1'b1;
                    wb_d     = capWb_q;
                    dest_d   = capDest_q;
                    wbData_d = selectWb(capWb_q[1:0], capAlu_q,
                                        capLoad_q ? mem_rdata : '0, capZp_q, capPc_q);
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt_q + 5'd1 == 5'(TIMEOUT_CYCLES)) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign stall_out     = (state_q == ACCESS);
    assign mem_req       = (state_q == ACCESS);
    assign mem_we        = memWe_q;
    assign mem_addr      = memAddr_q;
    assign mem_wdata     = memWdata_q;
    assign valid_out     = valid_q;
    assign WB_out        = wb_q;
    assign Dest_out      = dest_q;
    assign WB_data_out   = wbData_q;
    assign reg_write_out = valid_q & wb_q[2];
`ifdef MEM_TIMEOUT_EN
    assign mem_err       = err_q;
`else
    assign mem_err       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed self-checking bench for mem_stage_ctrl with hand-computed expectations.
// The timeout scenario runs only when MEM_TIMEOUT_EN is defined.
module tb_mem_stage_ctrl;

    localparam int DATA_W = 16;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              valid_in = 1'b0;
    logic [DATA_W-1:0] PC_plus1_in = '0;
    logic [2:0]        WB_in = '0;
    logic [1:0]        Memory_in = '0;
    logic [DATA_W-1:0] ALU_in = '0;
    logic [DATA_W-1:0] Memory_data_write_in = '0;
    logic [DATA_W-1:0] Zero_pad_in = '0;
    logic [2:0]        Dest_in = '0;
    logic              stall_out;
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              mem_ack = 1'b0;
    logic              valid_out;
    logic [2:0]        WB_out;
    logic [2:0]        Dest_out;
    logic [DATA_W-1:0] WB_data_out;
    logic              reg_write_out;
    logic              mem_err;

    int checkCount = 0;
    int errorCount = 0;

    mem_stage_ctrl #(.DATA_W(DATA_W), .TIMEOUT_CYCLES(15)) dut (
        .clock(clock), .reset(reset), .valid_in(valid_in), .PC_plus1_in(PC_plus1_in),
        .WB_in(WB_in), .Memory_in(Memory_in), .ALU_in(ALU_in),
        .Memory_data_write_in(Memory_data_write_in), .Zero_pad_in(Zero_pad_in),
        .Dest_in(Dest_in), .stall_out(stall_out), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .valid_out(valid_out), .WB_out(WB_out), .Dest_out(Dest_out),
        .WB_data_out(WB_data_out), .reg_write_out(reg_write_out), .mem_err(mem_err)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] memOp, input logic [2:0] wb,
                                 input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] wdata,
                                 input logic [2:0] dest);
        valid_in             = v;
        Memory_in            = memOp;
        WB_in                = wb;
        ALU_in               = alu;
        Memory_data_write_in = wdata;
        Dest_in              = dest;
    endtask

    initial begin
        PC_plus1_in = 16'h0101;
        Zero_pad_in = 16'h00F0;
        #12;
        checkOutput("rst_valid", valid_out, 0);
        checkOutput("rst_req", mem_req, 0);
        checkOutput("rst_stall", stall_out, 0);
        checkOutput("rst_addr", mem_addr, 0);
        checkOutput("rst_err", mem_err, 0);
        reset = 1'b1;
        step();

        // ALU op, single-cycle retire
        applyStimulus(1, 2'b00, 3'b100, 16'h1234, 16'h0000, 3'd3);
        step();
        checkOutput("alu_valid", valid_out, 1);
        checkOutput("alu_data", WB_data_out, 16'h1234);
        checkOutput("alu_dest", Dest_out, 3);
        checkOutput("alu_regwr", reg_write_out, 1);
        checkOutput("alu_stall", stall_out, 0);

        // Zero-pad and PC+1 selects, then a bubble
        applyStimulus(1, 2'b00, 3'b110, 16'h1234, 16'h0000, 3'd1);
        step();
        checkOutput("zp_data", WB_data_out, 16'h00F0);
        applyStimulus(1, 2'b00, 3'b011, 16'h1234, 16'h0000, 3'd1);
        step();
        checkOutput("pc_data", WB_data_out, 16'h0101);
        checkOutput("pc_regwr", reg_write_out, 0);
        applyStimulus(0, 2'b00, 3'b100, 16'h1234, 16'h0000, 3'd1);
        mem_ack = 1'b1;
        step();
        checkOutput("bubble_valid", valid_out, 0);
        checkOutput("bubble_wb", WB_out, 0);
        checkOutput("idle_ack_req", mem_req, 0);
        mem_ack = 1'b0;

        // Load with three wait cycles
        applyStimulus(1, 2'b10, 3'b101, 16'h0040, 16'h0000, 3'd4);
        step();
        applyStimulus(0, 2'b00, 3'b000, 16'h0000, 16'h0000, 3'd0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("ld_req", mem_req, 1);
            checkOutput("ld_we", mem_we, 0);
            checkOutput("ld_addr", mem_addr, 16'h0040);
            checkOutput("ld_stall", stall_out, 1);
            checkOutput("ld_bubble", valid_out, 0);
            if (i == 3) begin
                mem_ack   = 1'b1;
                mem_rdata = 16'hBEEF;
            end
            step();
        end
        mem_ack   = 1'b0;
        mem_rdata = 16'h0000;
        checkOutput("ld_valid", valid_out, 1);
        checkOutput("ld_data", WB_data_out, 16'hBEEF);
        checkOutput("ld_dest", Dest_out, 4);
        checkOutput("ld_req_drop", mem_req, 0);
        checkOutput("ld_stall_drop", stall_out, 0);

        // Store with zero-wait ack; mem-data select on a store yields 0
        applyStimulus(1, 2'b01, 3'b000, 16'h0010, 16'h00AA, 3'd2);
        step();
        applyStimulus(0, 2'b00, 3'b000, 16'h0000, 16'h0000, 3'd0);
        checkOutput("st_we", mem_we, 1);
        checkOutput("st_wdata", mem_wdata, 16'h00AA);
        checkOutput("st_addr", mem_addr, 16'h0010);
        mem_ack   = 1'b1;
        mem_rdata = 16'h7777;
        step();
        mem_ack = 1'b0;
        checkOutput("st_valid", valid_out, 1);
        checkOutput("st_regwr", reg_write_out, 0);
        checkOutput("st_data", WB_data_out, 16'h0010);
        applyStimulus(1, 2'b01, 3'b001, 16'h0020, 16'h0055, 3'd2);
        step();
        applyStimulus(0, 2'b00, 3'b000, 16'h0000, 16'h0000, 3'd0);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        checkOutput("st_memsel", WB_data_out, 16'h0000);

        // Memory_in=11 behaves as a load with the write suppressed
        applyStimulus(1, 2'b11, 3'b101, 16'h0033, 16'hFFFF, 3'd6);
        step();
        applyStimulus(0, 2'b00, 3'b000, 16'h0000, 16'h0000, 3'd0);
        checkOutput("ldst_we", mem_we, 0);
        mem_ack   = 1'b1;
        mem_rdata = 16'h4242;
        step();
        mem_ack = 1'b0;
        checkOutput("ldst_data", WB_data_out, 16'h4242);

        // Load followed by a stalled ALU op
        applyStimulus(1, 2'b10, 3'b101, 16'h0080, 16'h0000, 3'd5);
        step();
        applyStimulus(1, 2'b00, 3'b100, 16'h5555, 16'h0000, 3'd2);
        step();
        checkOutput("b2b_hold_valid", valid_out, 0);
        checkOutput("b2b_hold_stall", stall_out, 1);
        mem_ack   = 1'b1;
        mem_rdata = 16'h1111;
        step();
        mem_ack = 1'b0;
        checkOutput("b2b_ld_data", WB_data_out, 16'h1111);
        checkOutput("b2b_ld_dest", Dest_out, 5);
        step();
        applyStimulus(0, 2'b00, 3'b000, 16'h0000, 16'h0000, 3'd0);
        checkOutput("b2b_alu_valid", valid_out, 1);
        checkOutput("b2b_alu_data", WB_data_out, 16'h5555);
        checkOutput("b2b_alu_dest", Dest_out, 2);

        // Async reset in the middle of an access
        applyStimulus(1, 2'b10, 3'b101, 16'h0090, 16'h0000, 3'd1);
        step();
        applyStimulus(0, 2'b00, 3'b000, 16'h0000, 16'h0000, 3'd0);
        step();
        checkOutput("mid_req_before", mem_req, 1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_req", mem_req, 0);
        checkOutput("mid_rst_stall", stall_out, 0);
        checkOutput("mid_rst_valid", valid_out, 0);
        step();
        #2;
        reset = 1'b1;
        applyStimulus(1, 2'b00, 3'b100, 16'h0ABC, 16'h0000, 3'd7);
        step();
        applyStimulus(0, 2'b00, 3'b000, 16'h0000, 16'h0000, 3'd0);
        checkOutput("post_rst_valid", valid_out, 1);
        checkOutput("post_rst_data", WB_data_out, 16'h0ABC);
        checkOutput("post_rst_dest", Dest_out, 7);

`ifdef MEM_TIMEOUT_EN
        // No ack: abort on the fifteenth ACCESS cycle
        applyStimulus(1, 2'b10, 3'b101, 16'h00A0, 16'h0000, 3'd1);
        step();
        applyStimulus(0, 2'b00, 3'b000, 16'h0000, 16'h0000, 3'd0);
        for (int i = 0; i < 14; i++) step();
        checkOutput("to_req_before", mem_req, 1);
        checkOutput("to_err_before", mem_err, 0);
        step();
        checkOutput("to_req", mem_req, 0);
        checkOutput("to_err", mem_err, 1);
        checkOutput("to_valid", valid_out, 0);
        step();
        step();
        checkOutput("to_err_sticky", mem_err, 1);
        reset = 1'b0;
        #1;
        checkOutput("to_err_cleared", mem_err, 0);
        reset = 1'b1;
`else
        // Without the timeout an access waits indefinitely
        applyStimulus(1, 2'b10, 3'b101, 16'h00A0, 16'h0000, 3'd1);
        step();
        applyStimulus(0, 2'b00, 3'b000, 16'h0000, 16'h0000, 3'd0);
        for (int i = 0; i < 20; i++) step();
        checkOutput("wait_req", mem_req, 1);
        checkOutput("wait_err", mem_err, 0);
        mem_ack   = 1'b1;
        mem_rdata = 16'hCAFE;
        step();
        mem_ack = 1'b0;
        checkOutput("wait_data", WB_data_out, 16'hCAFE);
`endif

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Consumer side of the EX/MEM pipeline register in the 16-bit RISC core.
- Takes the registered EX/MEM bundle, runs the data-memory access over a req/ack bus and stalls upstream while the access is pending.
- Selects the write-back value and registers the MEM/WB bundle for the write-back stage.

Parameters:
- DATA_W, 16, datapath, address and PC width.
- TIMEOUT_CYCLES, 15, max ACCESS cycles before abort (MEM_TIMEOUT_EN only).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 = reset asserted.
- valid_in  in  1  EX/MEM bundle valid.
- PC_plus1_in  in  DATA_W  PC+1 of the instruction.
- WB_in  in  3  [2]=reg write enable; [1:0]=result select: 00 ALU, 01 mem data, 10 zero-pad, 11 PC+1.
- Memory_in  in  2  [1]=load, [0]=store.
- ALU_in  in  DATA_W  ALU result; also the memory address.
- Memory_data_write_in  in  DATA_W  store data.
- Zero_pad_in  in  DATA_W  zero-padded immediate.
- Dest_in  in  3  destination register.
- stall_out  out  1  upstream holds the EX/MEM register while high.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write.
- mem_addr  out  DATA_W  address.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion pulse.
- valid_out  out  1  MEM/WB valid.
- WB_out  out  3  WB control passed through.
- Dest_out  out  3  destination passed through.
- WB_data_out  out  DATA_W  selected write-back value.
- reg_write_out  out  1  valid_out AND WB_out[2].
- mem_err  out  1  sticky timeout flag (0 when feature is off).

Behaviour:
- Reset (reset=0, async): state IDLE.
  - stall_out, mem_req, mem_we and mem_err = 0.
  - All MEM/WB outputs = 0; mem_addr and mem_wdata = 0.
  - Reset mid-access: mem_req drops immediately and the transaction is abandoned; no output is produced.
- FSM states: IDLE and ACCESS.
- IDLE:
  - Inputs are sampled every edge.
  - valid_in=0: MEM/WB loads valid_out=0 with all fields 0.
  - valid_in=1, Memory_in=00: MEM/WB loads the bundle (1-cycle latency); stay in IDLE.
  - valid_in=1, Memory_in!=00: capture the bundle internally and go to ACCESS.
    - Same edge: mem_req=1; mem_we = (Memory_in==01); mem_addr=ALU_in; mem_wdata=Memory_data_write_in; stall_out=1.
    - MEM/WB loads valid_out=0 (bubble).
  - Memory_in=11: treated as a load; the write is suppressed.
- ACCESS:
  - Inputs are ignored; mem_req, mem_we, mem_addr and mem_wdata are held stable; stall_out=1.
  - On an edge with mem_ack=1: MEM/WB loads the captured bundle.
    - For a load, mem_rdata is latched for select 01.
    - mem_req=0, stall_out=0, next state IDLE.
    - The next instruction is accepted on the following edge.
  - Latency with a zero-wait memory: 2 edges from accept to valid_out.
- Stores retire with valid_out=1.
  - WB_data_out follows the select; mem-data select on a store returns 0.
- Write-back select: 00 ALU_in, 01 mem read data (captured on ack), 10 Zero_pad_in, 11 PC_plus1_in.
- mem_ack while not in ACCESS is ignored.
- Only one outstanding access at a time.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- When defined:
  - A 5-bit counter clears on entry to ACCESS and increments each ACCESS cycle without ack.
  - When it reaches TIMEOUT_CYCLES: abort, mem_req=0, mem_err=1 (sticky until reset), MEM/WB loads valid_out=0 (instruction dropped), return to IDLE.
  - mem_ack on the same edge as the timeout wins: normal completion.
- When not defined: no counter; ACCESS waits indefinitely; mem_err tied 0.

Test Plan:
- ALU op (valid_in=1, Memory_in=00, WB_in=100, ALU_in=0x1234, Dest_in=3) -> next edge: valid_out=1, WB_data_out=0x1234, Dest_out=3, reg_write_out=1, stall_out=0.
- Load (Memory_in=10, ALU_in=0x0040, WB_in=101); ack after 3 wait cycles with mem_rdata=0xBEEF:
  - mem_req=1, mem_we=0, mem_addr=0x0040 held 4 cycles; stall_out=1 throughout.
  - valid_out=1, WB_data_out=0xBEEF on the ack edge.
- Store (Memory_in=01, ALU_in=0x0010, Memory_data_write_in=0x00AA, WB_in=000), zero-wait ack -> mem_we=1, mem_wdata=0x00AA; valid_out=1, reg_write_out=0 two edges after accept.
- Back-to-back load then ALU op -> the ALU op is held by the stall and appears on valid_out exactly one edge after the load's write-back.
- reset driven low during ACCESS with no ack -> mem_req, stall_out and valid_out drop immediately; after release, the next valid_in is processed normally.
- MEM_TIMEOUT_EN defined, TIMEOUT_CYCLES=15, no ack -> on the 15th ACCESS cycle: mem_req=0, mem_err=1, valid_out=0; mem_err stays 1 until reset.
